// File: rtl/status_unit.sv
// NZCV status register with ARM-style condition evaluation for the ID stage.
// Optional macro STATUS_BYPASS_EN forwards this cycle's new flags to Cond_Pass.
module status_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] Val1,
  input  logic [WIDTH-1:0] Val2,
  input  logic [3:0]       EXE_CMD,
  input  logic [WIDTH-1:0] ALU_Res,
  input  logic             S,
  input  logic             valid,
  input  logic             freeze,
  input  logic [3:0]       Cond,
  output logic [3:0]       Status,
  output logic             Cond_Pass
);

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_OR  = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_SUB = 4'b0011;
  localparam logic [3:0] CMD_XOR = 4'b0100;
  localparam logic [3:0] CMD_MOV = 4'b0101;
  localparam logic [3:0] CMD_CMP = 4'b0110;

  logic             upd;
  logic             a_msb;
  logic             b_msb;
  logic             res_n;
  logic             res_z;
  logic             add_c;
  logic             a_ge_b;
  logic [WIDTH-1:0] diff;
  logic [3:0]       next_flags;
  logic [3:0]       eff_flags;
  logic             fn, fz, fc, fv;

  // Commands above CMP are not flag-setting ALU ops and never touch Status.
  assign upd    = valid & S & ~freeze & (EXE_CMD <= CMD_CMP);
  assign a_msb  = Val1[WIDTH-1];
  assign b_msb  = Val2[WIDTH-1];
  assign res_n  = ALU_Res[WIDTH-1];
  assign res_z  = ~|ALU_Res;
  assign add_c  = ({1'b0, Val1} + {1'b0, Val2}) > {1'b0, {WIDTH{1'b1}}};
  assign a_ge_b = Val1 >= Val2;
  // CMP delivers a 0/1 result on ALU_Res, so its flags come from a private subtract.
  assign diff   = Val1 - Val2;

  always_comb begin
    next_flags = Status;
    case (EXE_CMD)
      CMD_AND, CMD_OR, CMD_XOR, CMD_MOV:
        next_flags = {res_n, res_z, Status[1:0]};
      CMD_ADD:
        next_flags = {res_n, res_z, add_c, (a_msb == b_msb) & (res_n != a_msb)};
      CMD_SUB:
        next_flags = {res_n, res_z, a_ge_b, (a_msb != b_msb) & (res_n != a_msb)};
      CMD_CMP:
        next_flags = {diff[WIDTH-1], ~|diff, a_ge_b,
                      (a_msb != b_msb) & (diff[WIDTH-1] != a_msb)};
      default:
        next_flags = Status;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Status <= 4'b0000;
    end else if (upd) begin
      Status <= next_flags;
    end
  end

`ifdef STATUS_BYPASS_EN
  assign eff_flags = upd ? next_flags : Status;
`else
  assign eff_flags = Status;
`endif

  assign {fn, fz, fc, fv} = eff_flags;

  always_comb begin
    Cond_Pass = 1'b0;
    case (Cond)
      4'b0000: Cond_Pass = fz;
      4'b0001: Cond_Pass = ~fz;
      4'b0010: Cond_Pass = fc;
      4'b0011: Cond_Pass = ~fc;
      4'b0100: Cond_Pass = fn;
      4'b0101: Cond_Pass = ~fn;
      4'b0110: Cond_Pass = fv;
      4'b0111: Cond_Pass = ~fv;
      4'b1000: Cond_Pass = fc & ~fz;
      4'b1001: Cond_Pass = ~fc | fz;
      4'b1010: Cond_Pass = (fn == fv);
      4'b1011: Cond_Pass = (fn != fv);
      4'b1100: Cond_Pass = ~fz & (fn == fv);
      4'b1101: Cond_Pass = fz | (fn != fv);
      4'b1110: Cond_Pass = 1'b1;
      default: Cond_Pass = 1'b0;
    endcase
  end

endmodule

// File: doc/status_unit.md
Name: status_unit

Overview:
- EXE-stage producer of the 4-bit NZCV `Status` word that the ALU and the ID-stage condition logic consume.
- Recomputes flags from ALU operands and result for flag-setting instructions and holds them in a status register.
- Evaluates the 4-bit ARM-style condition field of the instruction in ID, producing `Cond_Pass` for issue/branch gating.

Parameters:
- WIDTH, 32, operand/result width; flag logic uses bit WIDTH-1 as sign.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- Val1  input  WIDTH  ALU operand 1 (same value fed to ALU)
- Val2  input  WIDTH  ALU operand 2
- EXE_CMD  input  4  ALU command of instruction in EXE
- ALU_Res  input  WIDTH  ALU result for instruction in EXE
- S  input  1  instruction in EXE sets flags
- valid  input  1  EXE slot holds a real (non-bubble) instruction
- freeze  input  1  pipeline stall; hold status register
- Cond  input  4  condition field of instruction in ID
- Status  output  4  registered flags {N,Z,C,V} = Status[3:0]
- Cond_Pass  output  1  condition of ID instruction satisfied

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-low; `Status` = 4'b0000 at the first rising clk edge with rst_n=0.
- Reset mid-operation: reset beats any simultaneous update; `Status` reads 0 the cycle after.
- Update enable: upd = valid & S & ~freeze & (EXE_CMD <= 4'b0110).
  - Unknown EXE_CMD never updates, even with S=1.
  - When upd=0, `Status` holds.
- Latency: flags visible on `Status` one cycle after the EXE instruction (registered).
- Next-flag rules (r = ALU_Res, a = Val1, b = Val2, msb = bit WIDTH-1):
  - AND(0000), OR(0001), XOR(0100), MOV(0101): N=r[msb], Z=(r==0); C and V keep their current values.
  - ADD(0010): compute s = {1'b0,a}+{1'b0,b} at WIDTH+1 bits.
    - N=r[msb], Z=(r==0), C=s[WIDTH].
    - V=(a[msb]==b[msb]) & (r[msb]!=a[msb]).
  - SUB(0011): N=r[msb], Z=(r==0).
    - C = ~borrow, i.e. (a >= b) unsigned.
    - V=(a[msb]!=b[msb]) & (r[msb]!=a[msb]).
  - CMP(0110): ALU_Res is a 0/1 compare, so it is NOT used. The unit computes d=a-b internally.
    - N=d[msb], Z=(d==0), C=(a>=b) unsigned.
    - V=(a[msb]!=b[msb]) & (d[msb]!=a[msb]).
- Cond_Pass: combinational from effective flags F (see Optional Feature).
  - 0000 EQ Z; 0001 NE !Z
  - 0010 CS C; 0011 CC !C
  - 0100 MI N; 0101 PL !N
  - 0110 VS V; 0111 VC !V
  - 1000 HI C&!Z; 1001 LS !C|Z
  - 1010 GE N==V; 1011 LT N!=V
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V)
  - 1110 AL 1; 1111 reserved → 0
- During reset (rst_n=0), `Cond_Pass` evaluates against the flags in effect that cycle; no special masking.
- Freeze with valid&S: no update; a freeze/unfreeze sequence must yield exactly one update for that instruction.

Optional Feature:
- Macro: STATUS_BYPASS_EN.
- Defined:
  - F = next flags when upd=1, else the registered `Status`.
  - A flag-setter in EXE and a dependent conditional instruction in ID resolve in the same cycle, with no bubble.
- Undefined:
  - F = registered `Status` only.
  - The hazard unit must insert one bubble after any S=1 instruction.
- `Status` port timing is identical in both builds.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with valid=1, S=1, ADD → `Status`=0000; then Cond=0000(EQ) → Cond_Pass=0.
- SUB equal: SUB a=5, b=5, r=0, S=1 → next cycle `Status`=0110 (Z=1, C=1).
  - Cond=0000 → 1; Cond=1100(GT) → 0.
- ADD overflow: ADD a=32'h7FFFFFFF, b=1, r=32'h80000000, S=1 → `Status`=1001 (N, V).
  - ADD a=32'hFFFFFFFF, b=1, r=0 → `Status`=0110.
- CMP ignores result: CMP a=3, b=7, ALU_Res=1 → `Status`=1000 (N=1, C=0); Cond=1011(LT) → 1.
- Logic ops and holds:
  - Preload C=1,V=1, then AND with r=0, S=1 → `Status`=0111.
  - S=0 or freeze=1 or EXE_CMD=4'b1001 → `Status` unchanged.
  - Cond=1111 → 0.
- Bypass: same cycle, SUB a=b with upd=1 and Cond=0000.
  - With STATUS_BYPASS_EN → Cond_Pass=1.
  - Without it (prior `Status`=0000) → Cond_Pass=0, becoming 1 the next cycle.
